// File: rtl/gemm_da_sequencer.sv
// Job-level sequencer for the bit-serial DA GEMM array: tile handshake, array
// bit/row stepping, and a row-result FIFO presented as a valid/ready stream.
module gemm_da_sequencer #(
   parameter int DATA_WIDTH_A   = 8,
   parameter int DATA_WIDTH_OUT = 8,
   parameter int M              = 2,
   parameter int N              = 4,
   parameter int OUT_DEPTH      = 4,
   parameter int GRP_W          = 16,
   localparam int RW            = (M > 1) ? $clog2(M) : 1,
   localparam int DW            = N * DATA_WIDTH_OUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [GRP_W-1:0] num_groups,
   input  logic             bias_cfg,
   output logic             busy,
   output logic             done,
   output logic             tile_req,
   input  logic             tile_ack,
   output logic [GRP_W-1:0] tile_idx,
   output logic             arr_gen_done,
   output logic             arr_bias_en,
   output logic             arr_clr,
   input  logic [DW-1:0]    arr_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic [RW-1:0]    out_row,
   output logic             out_last
);
   localparam int BW = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = $clog2(OUT_DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [GRP_W-1:0] r_num_groups, r_grp_cnt;
   logic             r_bias;
   logic [BW-1:0]    r_bit_cnt;
   logic [RW-1:0]    r_row_cnt;

   logic [DW-1:0]    r_mem_data [OUT_DEPTH];
   logic [RW-1:0]    r_mem_row  [OUT_DEPTH];
   logic             r_mem_last [OUT_DEPTH];
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_bit_wrap, w_row_last, w_more_grp, w_room;
   logic             w_push, w_pop, w_push_last;
   logic [RW-1:0]    w_push_row;

   assign w_bit_wrap = (r_bit_cnt == BW'(DATA_WIDTH_A - 1));
   assign w_row_last = (r_row_cnt == RW'(M - 1));
   assign w_more_grp = (({1'b0, r_grp_cnt} + (GRP_W+1)'(1)) < {1'b0, r_num_groups});
   // Admitting a tile only with M free slots means captures never need to stall.
   assign w_room     = (r_count <= CW'(OUT_DEPTH - M));

   // Row r lands when the array has finished it, i.e. on the first bit of row r+1.
   assign w_push      = ((r_state == S_RUN) && (r_bit_cnt == '0) && (r_row_cnt != '0))
                        || (r_state == S_DRAIN);
   assign w_push_row  = (r_state == S_DRAIN) ? RW'(M - 1) : (r_row_cnt - RW'(1));
   assign w_push_last = (r_state == S_DRAIN) && !w_more_grp;
   assign w_pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (num_groups == '0) ? S_DONE : S_LOAD;
         S_LOAD:  if (tile_ack && w_room) w_next = S_RUN;
         S_RUN:   if (w_bit_wrap && w_row_last) w_next = S_DRAIN;
         S_DRAIN: w_next = w_more_grp ? S_LOAD : S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_num_groups <= '0;
         r_grp_cnt    <= '0;
         r_bias       <= 1'b0;
         r_bit_cnt    <= '0;
         r_row_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_num_groups <= num_groups;
               r_bias       <= bias_cfg;
               r_grp_cnt    <= '0;
            end
            S_LOAD: begin
               r_bit_cnt <= '0;
               r_row_cnt <= '0;
            end
            S_RUN: begin
               if (w_bit_wrap) begin
                  r_bit_cnt <= '0;
                  r_row_cnt <= w_row_last ? '0 : (r_row_cnt + RW'(1));
               end else begin
                  r_bit_cnt <= r_bit_cnt + BW'(1);
               end
            end
            S_DRAIN: if (w_more_grp) r_grp_cnt <= r_grp_cnt + GRP_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_row[i]  <= '0;
            r_mem_last[i] <= 1'b0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= arr_result;
            r_mem_row[r_wr_ptr]  <= w_push_row;
            r_mem_last[r_wr_ptr] <= w_push_last;
            r_wr_ptr <= (r_wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : (r_wr_ptr + PW'(1));
         end
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : (r_rd_ptr + PW'(1));
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   assign busy         = (r_state != S_IDLE);
   assign done         = (r_state == S_DONE);
   assign tile_req     = (r_state == S_LOAD);
   assign arr_clr      = (r_state == S_LOAD);
   assign tile_idx     = r_grp_cnt;
   assign arr_gen_done = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign arr_bias_en  = arr_gen_done && r_bias;
   assign out_valid    = (r_count != '0);
   assign out_data     = r_mem_data[r_rd_ptr];
   assign out_row      = r_mem_row[r_rd_ptr];
   assign out_last     = out_valid && r_mem_last[r_rd_ptr];
endmodule
